// File: rtl/updown_counter_sched_pkg.sv
// Shared op codes, FSM states and a small decode helper for the
// up/down counter command scheduler.
package updown_counter_sched_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_GRANT = 2'b01,
    S_RUN   = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  function automatic logic is_step_op(input op_e op);
    return (op == OP_UP) || (op == OP_DOWN);
  endfunction

endpackage

// File: rtl/updown_counter_sched_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins outright, and on a
// tie the requester that was not served last wins.
module rr_arb2
  import updown_counter_sched_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/updown_counter_sched.sv
// Schedules commands from two requesters onto one shared up/down counter,
// driving its enable/direction/load controls from registered outputs.
module updown_counter_sched
  import updown_counter_sched_pkg::*;
#(
  parameter int CNT_W  = 2,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [1:0]        op0,
  input  logic [STEP_W-1:0] arg0,
  input  logic              req1,
  input  logic [1:0]        op1,
  input  logic [STEP_W-1:0] arg1,
  output logic              ack0,
  output logic              ack1,
  output logic              done0,
  output logic              done1,
  output logic              busy,
  output logic              cnt_en,
  output logic              cnt_ud,
  output logic              cnt_load,
  output logic [CNT_W-1:0]  cnt_din,
  input  logic [CNT_W-1:0]  cnt_q
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [STEP_W-1:0] arg_q, arg_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [1:0]        gnt;
  logic              run_step, run_load;
  logic              unused_q;

  // The counter value is only observed by the requesters, never used here.
  assign unused_q = ^cnt_q;

  rr_arb2 u_arb (
    .req  ({req1, req0}),
    .last (last_q),
    .gnt  (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      arg_q   <= '0;
      steps_q <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      steps_q <= steps_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    arg_d   = arg_q;
    steps_d = steps_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (|gnt) begin
          owner_d = gnt[1];
          op_d    = gnt[1] ? op_e'(op1) : op_e'(op0);
          arg_d   = gnt[1] ? arg1 : arg0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        last_d = owner_q;
        if (op_q == OP_NOP || (is_step_op(op_q) && arg_q == '0)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
          steps_d = is_step_op(op_q) ? arg_q : STEP_W'(1);
        end
      end
      S_RUN: begin
        steps_d = steps_q - STEP_W'(1);
        if (steps_q == STEP_W'(1)) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign run_step = (state_d == S_RUN) && is_step_op(op_d);
  assign run_load = (state_d == S_RUN) && (op_d == OP_LOAD);

  // Outputs are registered from the next-state decode so they line up with
  // the state they describe; direction and load value hold between uses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      busy     <= 1'b0;
      cnt_en   <= 1'b0;
      cnt_ud   <= 1'b0;
      cnt_load <= 1'b0;
      cnt_din  <= '0;
    end else begin
      ack0     <= (state_d == S_GRANT) && !owner_d;
      ack1     <= (state_d == S_GRANT) &&  owner_d;
      done0    <= (state_d == S_DONE)  && !owner_d;
      done1    <= (state_d == S_DONE)  &&  owner_d;
      busy     <= (state_d != S_IDLE);
      cnt_en   <= run_step;
      cnt_load <= run_load;
      if (run_step) cnt_ud <= (op_d == OP_UP);
      if (run_load) cnt_din <= arg_d[CNT_W-1:0];
    end
  end

endmodule
